// File: rtl/bnn_pkg.sv
// Shared types and elaboration-time helpers for the binary-neural-network layer engine.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam int DEF_IN_W        = 8;
  localparam int DEF_NUM_NEURONS = 8;
  localparam int DEF_LOAD_W      = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Index and counter registers need at least one bit even when the range collapses.
  function automatic int at_least_one(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Single binary neuron: XNOR the activation vector with the weights, count the
// agreeing bits and compare the count against the neuron's threshold.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int CNT_W = clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  i_vec,
  input  logic [IN_W-1:0]  i_weight,
  input  logic [CNT_W-1:0] i_thr,
  output logic             o_fire,
  output logic [CNT_W-1:0] o_sum
);

  logic [IN_W-1:0]  w_match;
  logic [CNT_W-1:0] w_sum;

  assign w_match = ~(i_vec ^ i_weight);

  // Population count of the matching bits; CNT_W holds 0..IN_W exactly.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_sum = w_sum + {{(CNT_W-1){1'b0}}, w_match[i]};
    end
  end

  assign o_sum  = w_sum;
  assign o_fire = (w_sum >= i_thr);

endmodule

// File: rtl/bnn_layer_engine.sv
// Time-multiplexed BNN layer: one neuron per clock through a shared XNOR-popcount
// unit, with per-neuron weights and thresholds loaded over a narrow beat bus.
module bnn_layer_engine
  import bnn_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int LOAD_W      = DEF_LOAD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [LOAD_W-1:0]      load_data,
  input  logic                   load_sync,
  output logic                   busy
);

  localparam int CNT_W  = clog2(IN_W + 1);
  localparam int REC_W  = IN_W + CNT_W;
  localparam int BEATS  = ceil_div(REC_W, LOAD_W);
  localparam int BUF_W  = BEATS * LOAD_W;
  localparam int IDX_W  = at_least_one(clog2(NUM_NEURONS));
  localparam int BEAT_W = at_least_one(clog2(BEATS));
  localparam logic [CNT_W-1:0] THR_RESET = CNT_W'(IN_W / 2);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_ptr;
  logic [BEAT_W-1:0]      r_beat;
  logic [BUF_W-1:0]       r_buf;
  logic [IN_W-1:0]        r_in;
  logic [NUM_NEURONS-1:0] r_out;
  logic                   r_out_valid;
  logic                   r_busy;
  logic [IN_W-1:0]        r_weight [NUM_NEURONS];
  logic [CNT_W-1:0]       r_thr    [NUM_NEURONS];

  logic             w_idle;
  logic             w_load_ready;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_beat_take;
  logic             w_sync_take;
  logic             w_last_beat;
  logic             w_commit;
  logic [BUF_W-1:0] w_buf;
  logic             w_fire;
  logic [CNT_W-1:0] w_sum_unused;

  // Loading owns the engine while it is idle, so a pending beat or sync blocks input.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_load_ready = w_idle && !reset;
  assign w_in_ready   = w_load_ready && !load_valid && !load_sync;
  assign w_in_fire    = in_valid && w_in_ready;
  assign w_sync_take  = load_sync && w_load_ready;
  assign w_beat_take  = load_valid && w_load_ready && !load_sync;
  assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
  assign w_commit     = w_beat_take && w_last_beat;

  // Record as it will look once the current beat is merged in.
  always_comb begin
    w_buf = r_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BEAT_W'(b)) begin
        w_buf[b*LOAD_W +: LOAD_W] = load_data;
      end else begin
        w_buf[b*LOAD_W +: LOAD_W] = r_buf[b*LOAD_W +: LOAD_W];
      end
    end
  end

  bnn_xnor_popcount #(
    .IN_W  (IN_W),
    .CNT_W (CNT_W)
  ) u_neuron (
    .i_vec    (r_in),
    .i_weight (r_weight[r_idx]),
    .i_thr    (r_thr[r_idx]),
    .o_fire   (w_fire),
    .o_sum    (w_sum_unused)
  );

  // Control FSM with registered result, valid and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_in        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_in    <= in_data;
            r_out   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_out[r_idx] <= w_fire;
          if (r_idx == IDX_W'(NUM_NEURONS - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat assembly and load pointer; sync wins over a same-cycle beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_beat <= '0;
      r_buf  <= '0;
    end else if (w_sync_take) begin
      r_ptr  <= '0;
      r_beat <= '0;
    end else if (w_beat_take) begin
      r_buf <= w_buf;
      if (w_last_beat) begin
        r_beat <= '0;
        if (r_ptr == IDX_W'(NUM_NEURONS - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_ptr + IDX_W'(1);
        end
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Weight and threshold storage; only a completed record is ever written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        r_weight[n] <= '1;
        r_thr[n]    <= THR_RESET;
      end
    end else if (w_commit) begin
      r_weight[r_ptr] <= w_buf[IN_W-1:0];
      r_thr[r_ptr]    <= w_buf[REC_W-1:IN_W];
    end
  end

  assign in_ready   = w_in_ready;
  assign load_ready = w_load_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out;
  assign busy       = r_busy;

endmodule
